// File: rtl/multiword_add_seq.sv
// -----------------------------------------------------------------------------
// multiword_add_seq
//   Sequential multi-word adder controller. Wide operands are latched on a
//   start request and added one 32-bit word per clock, least-significant word
//   first, through a single 33-bit word adder. The carry-out of each beat is
//   registered into the carry-in of the next beat. Sum words are collected into
//   a wide registered result.
//
//   Optional feature macro: ADD_OVF_EN adds a registered signed-overflow output.
//
// Parameters
//   NWORDS : number of 32-bit words per operand (2..16); W = 32*NWORDS
//
// Ports
//   clk   in   1  clock, rising edge
//   rst_n in   1  asynchronous active-low reset
//   start in   1  request, sampled only while idle
//   a     in   W  operand A, sampled on the accepting edge
//   b     in   W  operand B, sampled on the accepting edge
//   cin   in   1  carry-in to word 0, sampled on the accepting edge
//   busy  out  1  high while the add is running
//   done  out  1  one-cycle pulse, result valid
//   sum   out  W  registered result (modulo 2^W)
//   cout  out  1  registered carry-out of the top word
//   ovf   out  1  (ADD_OVF_EN only) two's-complement overflow of the result
// -----------------------------------------------------------------------------
module multiword_add_seq #(
    parameter int unsigned NWORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [32*NWORDS-1:0]   a,
    input  logic [32*NWORDS-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [32*NWORDS-1:0]   sum,
    output logic                   cout
`ifdef ADD_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int unsigned W    = 32 * NWORDS;
    localparam int unsigned IDXW = $clog2(NWORDS);
    localparam logic [IDXW-1:0] LastIdx = IDXW'(NWORDS - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e          r_state, w_state_d;
    logic [W-1:0]    r_a, w_a_d;
    logic [W-1:0]    r_b, w_b_d;
    logic [W-1:0]    r_sum, w_sum_d;
    logic [IDXW-1:0] r_idx, w_idx_d;
    logic            r_carry, w_carry_d;
    logic            r_cout, w_cout_d;
    logic            r_done, w_done_d;

    logic [31:0]     w_a_word;
    logic [31:0]     w_b_word;
    logic [32:0]     w_word;

    // One shared word adder; the current beat selects its slice by index.
    assign w_a_word = r_a[32*r_idx +: 32];
    assign w_b_word = r_b[32*r_idx +: 32];
    assign w_word   = {1'b0, w_a_word} + {1'b0, w_b_word} + {32'd0, r_carry};

`ifdef ADD_OVF_EN
    logic r_ovf, w_ovf_d;
    logic w_ovf_top;

    // Signed overflow: operands share a sign and the result sign differs.
    assign w_ovf_top = (w_a_word[31] == w_b_word[31]) && (w_word[31] != w_a_word[31]);
    assign ovf       = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_d;
        end
    end

    always_comb begin
        w_ovf_d = r_ovf;
        if (r_state == StRun && r_idx == LastIdx) begin
            w_ovf_d = w_ovf_top;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_a     <= w_a_d;
            r_b     <= w_b_d;
            r_sum   <= w_sum_d;
            r_idx   <= w_idx_d;
            r_carry <= w_carry_d;
            r_cout  <= w_cout_d;
            r_done  <= w_done_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_a_d     = r_a;
        w_b_d     = r_b;
        w_sum_d   = r_sum;
        w_idx_d   = r_idx;
        w_carry_d = r_carry;
        w_cout_d  = r_cout;
        w_done_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = StRun;
                    w_a_d     = a;
                    w_b_d     = b;
                    w_carry_d = cin;
                    w_idx_d   = '0;
                end
            end
            StRun: begin
                w_sum_d[32*r_idx +: 32] = w_word[31:0];
                w_carry_d               = w_word[32];
                if (r_idx == LastIdx) begin
                    w_state_d = StIdle;
                    w_cout_d  = w_word[32];
                    w_done_d  = 1'b1;
                    w_idx_d   = '0;
                end else begin
                    w_idx_d = r_idx + IDXW'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign busy = (r_state == StRun);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
